// File: rtl/env_capture_if.sv
// env_capture_if: source-side inputs and packed breakpoint outputs of the envelope capture block
`ifndef BITS
`define BITS 16
`endif
interface env_capture_if #(
   parameter int DEPTH = 4,
   parameter int LEN   = 2
);
   logic                       ena;
   logic                       arm;
   logic signed [`BITS-1:0]    sigIn;
   logic [DEPTH*LEN-1:0]       levels;
   logic [DEPTH*(LEN-1)-1:0]   times;
   logic                       busy;
   logic                       done;
   modport master (output ena, arm, sigIn, input levels, times, busy, done);
   modport slave  (input ena, arm, sigIn, output levels, times, busy, done);
endinterface

// File: rtl/env_capture.sv
// env_capture: records a signal's amplitude contour as packed level/time breakpoints for sequencer replay
`ifndef BITS
`define BITS 16
`endif
module env_capture #(
   parameter int DEPTH  = 4,
   parameter int LEN    = 2,
   parameter int TSCALE = 1
) (
   input logic        clk,
   input logic        rst,
   env_capture_if.slave bus
);
   localparam int SH = `BITS - DEPTH - 1;
   localparam int IW = (LEN > 2) ? $clog2(LEN - 1) : 1;
   localparam int PW = (TSCALE > 1) ? $clog2(TSCALE) : 1;
   localparam logic [DEPTH-1:0] MAXV = '1;
   localparam logic [PW-1:0]    PMAX = PW'(TSCALE - 1);
   localparam logic [IW-1:0]    ITOP = IW'(LEN - 2);
   localparam logic [0:0]       IDLE    = 1'b0;
   localparam logic [0:0]       CAPTURE = 1'b1;

   logic [0:0]               state;
   logic [DEPTH*LEN-1:0]     levels;
   logic [DEPTH*(LEN-1)-1:0] times;
   logic                     busy;
   logic                     done;
   logic [DEPTH-1:0]         held;
   logic [DEPTH-1:0]         tick;
   logic [IW-1:0]            idx;
   logic [PW-1:0]            prescale;
   logic [`BITS-1:0]         mag;
   logic [`BITS-1:0]         shifted;
   logic [DEPTH-1:0]         q;
   logic [DEPTH-1:0]         nt;
   logic                     boundary;
   logic                     commit;
   logic                     lastCommit;

   assign bus.levels = levels;
   assign bus.times  = times;
   assign bus.busy   = busy;
   assign bus.done   = done;

   // quantise |sigIn| to a DEPTH-bit level and decide whether this edge commits a breakpoint
   always_comb begin
      mag        = bus.sigIn[`BITS-1] ? -bus.sigIn : bus.sigIn;
      shifted    = mag >> SH;
      q          = (shifted > `BITS'(MAXV)) ? MAXV : shifted[DEPTH-1:0];
      nt         = tick + 1'b1;
      boundary   = (state == CAPTURE) && !bus.arm && (prescale == PMAX);
      commit     = boundary && ((q != held) || (nt == MAXV));
      lastCommit = commit && (idx == '0);
   end

   // capture state machine; done is cleared on every edge so it never outlasts one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         levels   <= '0;
         times    <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         held     <= '0;
         tick     <= '0;
         idx      <= '0;
         prescale <= '0;
      end else begin
         done <= bus.ena && lastCommit;
         if (bus.ena) begin
            if (bus.arm) begin
               levels   <= {q, {(DEPTH*(LEN-1)){1'b0}}};
               times    <= '0;
               held     <= q;
               idx      <= ITOP;
               tick     <= '0;
               prescale <= '0;
               busy     <= 1'b1;
               state    <= CAPTURE;
            end else if (state == CAPTURE) begin
               if (prescale != PMAX) begin
                  prescale <= prescale + 1'b1;
               end else begin
                  prescale <= '0;
                  if (commit) begin
                     times[int'(idx)*DEPTH +: DEPTH]  <= nt;
                     levels[int'(idx)*DEPTH +: DEPTH] <= q;
                     held <= q;
                     tick <= '0;
                     if (idx == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                     end else begin
                        idx <= idx - 1'b1;
                     end
                  end else begin
                     tick <= nt;
                  end
               end
            end
         end
      end
   end
endmodule

// File: tb/tb_env_capture.sv
// tb_env_capture: table vectors, corner sequences and random stimulus against a tick-counting reference model
`ifndef BITS
`define BITS 16
`endif
module tb_env_capture;
   localparam int DEPTH = 4;
   localparam int LEN = 3;
   localparam int TS = 2;
   localparam int MAXV = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   env_capture_if #(.DEPTH(DEPTH), .LEN(LEN)) bus ();
   env_capture #(.DEPTH(DEPTH), .LEN(LEN), .TSCALE(TS)) dut (.clk(clk), .rst(rst), .bus(bus));

   typedef struct {
      bit r; bit e; bit a;
      logic [15:0] s;
      logic [11:0] lv;
      logic [7:0] tm;
      bit b; bit d;
   } vec_t;
   vec_t tbl[$];

   int nCmp = 0;
   int nBad = 0;

   int mlv[LEN];
   int mtm[LEN-1];
   int held, slot, en, lastB;
   bit cap, mdone;

   function automatic int quant(logic [15:0] s);
      int v;
      v = int'($signed(s));
      if (v < 0) v = -v;
      v = v / 2048;
      return (v > MAXV) ? MAXV : v;
   endfunction

   function automatic logic [11:0] packLv();
      logic [11:0] v;
      for (int k = 0; k < LEN; k++) v[k*DEPTH +: DEPTH] = 4'(mlv[k]);
      return v;
   endfunction

   function automatic logic [7:0] packTm();
      logic [7:0] v;
      for (int k = 0; k < LEN-1; k++) v[k*DEPTH +: DEPTH] = 4'(mtm[k]);
      return v;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
      end
   endtask

   task automatic model(input bit r, input bit e, input bit a, input logic [15:0] s);
      int q, nt, b;
      mdone = 0;
      if (r) begin
         foreach (mlv[k]) mlv[k] = 0;
         foreach (mtm[k]) mtm[k] = 0;
         held = 0; slot = 0; en = 0; lastB = 0; cap = 0;
      end else if (e) begin
         q = quant(s);
         if (a) begin
            foreach (mlv[k]) mlv[k] = 0;
            foreach (mtm[k]) mtm[k] = 0;
            mlv[LEN-1] = q;
            held = q; slot = LEN-2; en = 0; lastB = 0; cap = 1;
         end else if (cap) begin
            en++;
            if (en % TS == 0) begin
               b = en / TS;
               nt = b - lastB;
               if (q != held || nt == MAXV) begin
                  mtm[slot] = nt;
                  mlv[slot] = q;
                  held = q;
                  lastB = b;
                  if (slot == 0) begin
                     cap = 0;
                     mdone = 1;
                  end else slot--;
               end
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit a, input logic [15:0] s);
      rst = r; bus.ena = e; bus.arm = a; bus.sigIn = s;
      @(posedge clk);
      #1;
      model(r, e, a, s);
      chk("model_levels", 32'(bus.levels), 32'(packLv()));
      chk("model_times", 32'(bus.times), 32'(packTm()));
      chk("model_busy", 32'(bus.busy), 32'(cap));
      chk("model_done", 32'(bus.done), 32'(mdone));
   endtask

   function automatic logic [15:0] basicSig(int c);
      return (c < 5) ? 16'h2000 : (c < 7) ? 16'h7FFF : 16'h0000;
   endfunction

   int doneAt;

   initial begin
      rst = 1'b1; bus.ena = 1'b0; bus.arm = 1'b0; bus.sigIn = '0;
      // basic capture, quantiser and saturation vectors
      tbl.push_back('{1, 1, 0, 16'h0000, 12'h000, 8'h00, 0, 0});
      tbl.push_back('{0, 1, 1, 16'h2000, 12'h400, 8'h00, 1, 0});
      for (int c = 1; c <= 5; c++) tbl.push_back('{0, 1, 0, basicSig(c), 12'h400, 8'h00, 1, 0});
      tbl.push_back('{0, 1, 0, 16'h7FFF, 12'h4F0, 8'h30, 1, 0});
      tbl.push_back('{0, 1, 0, 16'h0000, 12'h4F0, 8'h30, 1, 0});
      tbl.push_back('{0, 1, 0, 16'h0000, 12'h4F0, 8'h31, 0, 1});
      tbl.push_back('{0, 1, 0, 16'h0000, 12'h4F0, 8'h31, 0, 0});
      tbl.push_back('{0, 1, 0, 16'h1234, 12'h4F0, 8'h31, 0, 0});
      tbl.push_back('{0, 1, 1, 16'h8000, 12'hF00, 8'h00, 1, 0});
      tbl.push_back('{0, 1, 1, 16'hE000, 12'h400, 8'h00, 1, 0});
      tbl.push_back('{0, 1, 1, 16'h07FF, 12'h000, 8'h00, 1, 0});
      tbl.push_back('{0, 0, 1, 16'h7FFF, 12'h000, 8'h00, 1, 0});
      tbl.push_back('{1, 1, 0, 16'h0000, 12'h000, 8'h00, 0, 0});
      foreach (tbl[i]) begin
         step(tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].s);
         chk($sformatf("vec%0d_levels", i), 32'(bus.levels), 32'(tbl[i].lv));
         chk($sformatf("vec%0d_times", i), 32'(bus.times), 32'(tbl[i].tm));
         chk($sformatf("vec%0d_busy", i), 32'(bus.busy), 32'(tbl[i].b));
         chk($sformatf("vec%0d_done", i), 32'(bus.done), 32'(tbl[i].d));
      end

      // time saturation: constant level forces commits every 15 ticks
      step(0, 1, 1, 16'h2000);
      doneAt = -1;
      for (int c = 1; c <= 62; c++) begin
         step(0, 1, 0, 16'h2000);
         if (c == 30) begin
            chk("sat30_times", 32'(bus.times), 32'h0F0);
            chk("sat30_levels", 32'(bus.levels), 32'h440);
         end
         if (bus.done && doneAt < 0) doneAt = c;
      end
      chk("sat_levels", 32'(bus.levels), 32'h444);
      chk("sat_times", 32'(bus.times), 32'hFF);
      chk("sat_done_edge", 32'(doneAt), 32'd60);
      step(1, 1, 0, 16'h0000);

      // ena gating: three frozen clocks shift the commits by three edges
      doneAt = -1;
      begin
         int c;
         c = 0;
         for (int k = 0; k < 14; k++) begin
            if (k >= 4 && k <= 6) step(0, 0, 0, 16'h2000);
            else begin
               step(0, 1, (c == 0), basicSig(c));
               c++;
            end
            if (bus.done && doneAt < 0) doneAt = k;
         end
      end
      chk("gate_levels", 32'(bus.levels), 32'h4F0);
      chk("gate_times", 32'(bus.times), 32'h31);
      chk("gate_done_edge", 32'(doneAt), 32'd11);
      step(1, 1, 0, 16'h0000);

      // re-arm at cycle 7 then reset mid-capture
      step(0, 1, 1, 16'h2000);
      for (int c = 1; c <= 6; c++) step(0, 1, 0, basicSig(c));
      chk("rearm_pre_levels", 32'(bus.levels), 32'h4F0);
      step(0, 1, 1, 16'h3000);
      chk("rearm_levels", 32'(bus.levels), 32'h600);
      chk("rearm_times", 32'(bus.times), 32'h00);
      chk("rearm_done", 32'(bus.done), 32'd0);
      chk("rearm_busy", 32'(bus.busy), 32'd1);
      step(0, 1, 0, 16'h3000);
      chk("rearm_nodone", 32'(bus.done), 32'd0);
      step(0, 1, 0, 16'h7FFF);
      step(1, 1, 0, 16'h7FFF);
      chk("rst_levels", 32'(bus.levels), 32'h000);
      chk("rst_times", 32'(bus.times), 32'h00);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);

      // random stimulus against the model
      begin
         logic [15:0] s;
         s = 16'h0000;
         for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 4) == 0) s = 16'($urandom);
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 39) == 0), s);
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end
endmodule
